// File: rtl/snell_refract.sv
// Refraction-angle solver: finds the smallest integer angle theeta2 with
// n2*sin(theeta2) >= n1*sin(theeta1) by a linear search over a sine ROM.
module snell_refract #(
    parameter int unsigned N_W   = 4,
    parameter int unsigned ANG_W = 7,
    parameter int unsigned SIN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_W-1:0]   n1,
    input  logic [N_W-1:0]   n2,
    input  logic [ANG_W-1:0] theeta1,
    output logic [ANG_W-1:0] theeta2,
    output logic             tir,
    output logic             err,
    output logic             busy,
    output logic             done
);

    localparam int unsigned P_W     = N_W + SIN_W;
    localparam int unsigned ANG_MAX = 90;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SEARCH,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [N_W-1:0]     n1_q, n1_d;
    logic [N_W-1:0]     n2_q, n2_d;
    logic [ANG_W-1:0]   t1_q, t1_d;
    logic [ANG_W-1:0]   idx_q, idx_d;
    logic [P_W-1:0]     p_q, p_d;
    logic [ANG_W-1:0]   theeta2_d;
    logic               tir_d, err_d, busy_d, done_d;
    logic [ANG_W-1:0]   rom_addr_c;
    logic [SIN_W-1:0]   rom_val_c;
    logic [P_W-1:0]     q_c;

    // round(sin(a) * 65535) for a = 0..90 degrees
    function automatic logic [15:0] sin_rom(input logic [6:0] a);
        logic [15:0] v;
        v = 16'd0;
        case (a)
            7'd0:  v = 16'd0;     7'd1:  v = 16'd1144;  7'd2:  v = 16'd2287;  7'd3:  v = 16'd3430;
            7'd4:  v = 16'd4571;  7'd5:  v = 16'd5712;  7'd6:  v = 16'd6850;  7'd7:  v = 16'd7987;
            7'd8:  v = 16'd9121;  7'd9:  v = 16'd10252; 7'd10: v = 16'd11380; 7'd11: v = 16'd12505;
            7'd12: v = 16'd13625; 7'd13: v = 16'd14742; 7'd14: v = 16'd15854; 7'd15: v = 16'd16962;
            7'd16: v = 16'd18064; 7'd17: v = 16'd19161; 7'd18: v = 16'd20251; 7'd19: v = 16'd21336;
            7'd20: v = 16'd22414; 7'd21: v = 16'd23486; 7'd22: v = 16'd24550; 7'd23: v = 16'd25607;
            7'd24: v = 16'd26655; 7'd25: v = 16'd27696; 7'd26: v = 16'd28729; 7'd27: v = 16'd29752;
            7'd28: v = 16'd30767; 7'd29: v = 16'd31772; 7'd30: v = 16'd32768; 7'd31: v = 16'd33753;
            7'd32: v = 16'd34728; 7'd33: v = 16'd35693; 7'd34: v = 16'd36647; 7'd35: v = 16'd37589;
            7'd36: v = 16'd38521; 7'd37: v = 16'd39440; 7'd38: v = 16'd40347; 7'd39: v = 16'd41243;
            7'd40: v = 16'd42125; 7'd41: v = 16'd42995; 7'd42: v = 16'd43851; 7'd43: v = 16'd44695;
            7'd44: v = 16'd45524; 7'd45: v = 16'd46340; 7'd46: v = 16'd47142; 7'd47: v = 16'd47929;
            7'd48: v = 16'd48702; 7'd49: v = 16'd49460; 7'd50: v = 16'd50203; 7'd51: v = 16'd50930;
            7'd52: v = 16'd51642; 7'd53: v = 16'd52339; 7'd54: v = 16'd53019; 7'd55: v = 16'd53683;
            7'd56: v = 16'd54331; 7'd57: v = 16'd54962; 7'd58: v = 16'd55577; 7'd59: v = 16'd56174;
            7'd60: v = 16'd56755; 7'd61: v = 16'd57318; 7'd62: v = 16'd57864; 7'd63: v = 16'd58392;
            7'd64: v = 16'd58902; 7'd65: v = 16'd59395; 7'd66: v = 16'd59869; 7'd67: v = 16'd60325;
            7'd68: v = 16'd60763; 7'd69: v = 16'd61182; 7'd70: v = 16'd61583; 7'd71: v = 16'd61965;
            7'd72: v = 16'd62327; 7'd73: v = 16'd62671; 7'd74: v = 16'd62996; 7'd75: v = 16'd63302;
            7'd76: v = 16'd63588; 7'd77: v = 16'd63855; 7'd78: v = 16'd64103; 7'd79: v = 16'd64331;
            7'd80: v = 16'd64539; 7'd81: v = 16'd64728; 7'd82: v = 16'd64897; 7'd83: v = 16'd65047;
            7'd84: v = 16'd65176; 7'd85: v = 16'd65286; 7'd86: v = 16'd65375; 7'd87: v = 16'd65445;
            7'd88: v = 16'd65495; 7'd89: v = 16'd65525; 7'd90: v = 16'd65535;
            default: v = 16'd0;
        endcase
        return v;
    endfunction

    // One ROM shared between the MUL lookup (theeta1) and the search (idx)
    always_comb begin
        rom_addr_c = (state == S_MUL) ? t1_q : idx_q;
        rom_val_c  = SIN_W'(sin_rom(7'(rom_addr_c)));
        q_c        = P_W'(n2_q) * P_W'(rom_val_c);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d   = state;
        n1_d      = n1_q;
        n2_d      = n2_q;
        t1_d      = t1_q;
        idx_d     = idx_q;
        p_d       = p_q;
        theeta2_d = theeta2;
        tir_d     = tir;
        err_d     = err;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    n1_d      = n1;
                    n2_d      = n2;
                    t1_d      = theeta1;
                    theeta2_d = '0;
                    tir_d     = 1'b0;
                    err_d     = 1'b0;
                    if ((n2 == '0) || (theeta1 > ANG_W'(ANG_MAX))) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_MUL;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_MUL: begin
                p_d     = P_W'(n1_q) * P_W'(rom_val_c);
                idx_d   = '0;
                state_d = S_SEARCH;
                busy_d  = 1'b1;
            end
            S_SEARCH: begin
                busy_d = 1'b1;
                if (q_c >= p_q) begin
                    theeta2_d = idx_q;
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else if (idx_q == ANG_W'(ANG_MAX)) begin
                    tir_d     = 1'b1;
                    theeta2_d = '0;
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    idx_d = idx_q + ANG_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            n1_q    <= '0;
            n2_q    <= '0;
            t1_q    <= '0;
            idx_q   <= '0;
            p_q     <= '0;
            theeta2 <= '0;
            tir     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            t1_q    <= t1_d;
            idx_q   <= idx_d;
            p_q     <= p_d;
            theeta2 <= theeta2_d;
            tir     <= tir_d;
            err     <= err_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_snell_refract.sv
// Directed bench for snell_refract: hand-computed angles, latencies, flags,
// asynchronous reset and start-while-busy behaviour.
module tb_snell_refract;

    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] n1, n2;
    logic [6:0] theeta1;
    logic [6:0] theeta2;
    logic       tir, err, busy, done;

    int errors = 0;
    int checks = 0;
    int lat;
    int lat2;
    int done_cnt;
    bit busy_ok;

    snell_refract dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .n1      (n1),
        .n2      (n2),
        .theeta1 (theeta1),
        .theeta2 (theeta2),
        .tir     (tir),
        .err     (err),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one job and wait for done; lat = edges after the accepting edge
    task automatic run_job(input logic [3:0] a, input logic [3:0] b, input logic [6:0] t,
                           output int l, output bit bok);
        @(negedge clk);
        n1 = a; n2 = b; theeta1 = t; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l = 0;
        bok = 1'b1;
        while (done !== 1'b1 && l < LIMIT) begin
            if (busy !== 1'b1) bok = 1'b0;
            @(posedge clk); #1;
            l++;
        end
        if (busy !== 1'b0) bok = 1'b0;
        if (done === 1'b1) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; n1 = '0; n2 = '0; theeta1 = '0;
        #3;
        chk("rst_theeta2", 32'(theeta2), 0);
        chk("rst_tir", 32'(tir), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        run_job(4'd10, 4'd10, 7'd30, lat, busy_ok);
        chk("eq30_lat", 32'(lat), 32);
        chk("eq30_theeta2", 32'(theeta2), 30);
        chk("eq30_tir", 32'(tir), 0);
        chk("eq30_err", 32'(err), 0);
        chk("eq30_busy", 32'(busy_ok), 1);

        // Asynchronous reset mid-cycle clears held outputs before any edge
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_theeta2", 32'(theeta2), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(done), 0);
        @(negedge clk);
        rst = 1'b1;

        run_job(4'd10, 4'd15, 7'd90, lat, busy_ok);
        chk("r15_lat", 32'(lat), 44);
        chk("r15_theeta2", 32'(theeta2), 42);
        chk("r15_tir", 32'(tir), 0);
        chk("r15_busy", 32'(busy_ok), 1);

        run_job(4'd15, 4'd10, 7'd45, lat, busy_ok);
        chk("tir_lat", 32'(lat), 92);
        chk("tir_flag", 32'(tir), 1);
        chk("tir_theeta2", 32'(theeta2), 0);
        chk("tir_err", 32'(err), 0);

        run_job(4'd15, 4'd10, 7'd0, lat, busy_ok);
        chk("zero_lat", 32'(lat), 2);
        chk("zero_theeta2", 32'(theeta2), 0);
        chk("zero_tir", 32'(tir), 0);

        run_job(4'd10, 4'd0, 7'd20, lat, busy_ok);
        chk("n2z_lat", 32'(lat), 0);
        chk("n2z_err", 32'(err), 1);
        chk("n2z_tir", 32'(tir), 0);
        chk("n2z_theeta2", 32'(theeta2), 0);
        chk("n2z_busy", 32'(busy_ok), 1);

        run_job(4'd10, 4'd10, 7'd100, lat, busy_ok);
        chk("ang_lat", 32'(lat), 0);
        chk("ang_err", 32'(err), 1);
        chk("ang_busy", 32'(busy_ok), 1);

        run_job(4'd0, 4'd10, 7'd60, lat, busy_ok);
        chk("n1z_lat", 32'(lat), 2);
        chk("n1z_theeta2", 32'(theeta2), 0);
        chk("n1z_err", 32'(err), 0);

        // Reset during SEARCH aborts the job with no done pulse
        @(negedge clk);
        n1 = 4'd10; n2 = 4'd15; theeta1 = 7'd90; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_theeta2", 32'(theeta2), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        done_cnt = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        chk("abort_nodone", 32'(done_cnt), 0);
        run_job(4'd10, 4'd15, 7'd90, lat, busy_ok);
        chk("after_abort_lat", 32'(lat), 44);
        chk("after_abort_theeta2", 32'(theeta2), 42);

        // start held high throughout a job
        @(negedge clk);
        n1 = 4'd10; n2 = 4'd10; theeta1 = 7'd5; start = 1'b1;
        @(posedge clk); #1;
        theeta1 = 7'd60;
        done_cnt = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_cnt++;
        end
        chk("hold_early_done", 32'(done_cnt), 0);
        @(posedge clk); #1;
        chk("hold_done", 32'(done), 1);
        chk("hold_theeta2", 32'(theeta2), 5);
        @(posedge clk); #1;
        chk("hold_idle_theeta2", 32'(theeta2), 5);
        chk("hold_idle_busy", 32'(busy), 0);
        chk("hold_idle_done", 32'(done), 0);
        @(posedge clk); #1;
        chk("rejob_busy", 32'(busy), 1);
        chk("rejob_clear", 32'(theeta2), 0);
        start = 1'b0;
        lat2 = 0;
        while (done !== 1'b1 && lat2 < LIMIT) begin
            @(posedge clk); #1;
            lat2++;
        end
        chk("rejob_lat", 32'(lat2), 62);
        chk("rejob_theeta2", 32'(theeta2), 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/snell_refract.md
Name: snell_refract

Overview:
- Inverse-direction companion to the refractive-index solver: takes n1, n2 and incidence angle theeta1, and computes refraction angle theeta2 from n1·sin(theeta1) = n2·sin(theeta2).
- Sequential: one multiply cycle, then a linear arcsine search over an internal sine ROM, one angle per clock.
- Flags total internal reflection (TIR) and illegal operands.
- Sits alongside the index solver in the optics datapath and uses the same integer-degree angle format and 4-bit index encoding.

Parameters:
- N_W, 4, width of n1/n2 (unsigned integer index code, tenths: 10 = 1.0).
- ANG_W, 7, angle width in integer degrees; legal range 0..90.
- SIN_W, 16, sine ROM word width; entry = round(sin(a)·(2^SIN_W−1)), entry[90] = 2^SIN_W−1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  request; sampled only in IDLE.
- n1  in  N_W  incident-medium index.
- n2  in  N_W  refracting-medium index.
- theeta1  in  ANG_W  incidence angle, degrees.
- theeta2  out  ANG_W  refraction angle, degrees.
- tir  out  1  total internal reflection result.
- err  out  1  illegal operands.
- busy  out  1  high in MUL and SEARCH.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE; theeta2=0, tir=0, err=0, busy=0, done=0; internal registers cleared. Reset mid-operation aborts the job with no done; the first start after release is served normally.
- States: IDLE, MUL, SEARCH, DONE. done is high only in DONE. busy is high only in MUL and SEARCH.
- IDLE + start=1 at edge k:
  - Latch n1, n2, theeta1.
  - Clear theeta2, tir, err.
  - If n2==0 or theeta1>90: set err=1, go to DONE. done is high in the cycle after edge k.
  - Otherwise go to MUL.
- start in any state other than IDLE is ignored and is not queued.
- MUL (1 cycle): P = n1 · sinrom[theeta1], width N_W+SIN_W, unsigned, no truncation. idx=0. Go to SEARCH.
- SEARCH (one idx per cycle):
  - Compute Q = n2 · sinrom[idx], full width.
  - If Q >= P: theeta2=idx, go to DONE.
  - Else if idx==90: tir=1, theeta2=0, go to DONE.
  - Else idx=idx+1.
- Rounding rule: the result is the smallest integer angle a with n2·sin(a) >= n1·sin(theeta1), i.e. a ceiling, using ROM values.
- Latency for a normal result a: done is high in the cycle after edge k+2+a. TIR: done is high after edge k+92.
- DONE (1 cycle): go to IDLE. A start present in the DONE cycle is ignored. Earliest re-accept is in the following IDLE cycle.
- theeta2, tir and err hold their values until the next accepted start.
- n1==0 gives P=0, so the search matches at idx=0: theeta2=0, no TIR, no err.
- n1==n2 returns theeta2==theeta1 exactly (equal ROM entries).
- ROM is combinational or synthesised constant logic of 91 entries. Indices above 90 are never addressed.

Test Plan:
- rst=0 asserted asynchronously mid-cycle, outputs checked before the next clk edge -> theeta2=0, tir=0, err=0, busy=0, done=0; repeated during SEARCH (n1=10, n2=15, theeta1=90) -> job aborted, no done pulse; the next start returns theeta2=42.
- n1=10, n2=10, theeta1=30, start at edge k -> busy high from k until DONE; done pulse after edge k+32; theeta2=30, tir=0, err=0.
- n1=10, n2=15, theeta1=90 -> theeta2=42 (sin41 < 0.6667 <= sin42); done after edge k+44.
- n1=15, n2=10, theeta1=45 -> tir=1, theeta2=0 after exhausting idx 0..90; done after edge k+92. n1=15, n2=10, theeta1=0 -> theeta2=0, done after edge k+2.
- n2=0, n1=10, theeta1=20 -> err=1, tir=0, theeta2=0, done in the cycle after edge k, busy never high. theeta1=100, n2=10 -> same err response.
- Pulse start on every cycle throughout a job (n1=n2=10, theeta1=5) -> exactly one done, theeta2=5; a second job starts only on the IDLE cycle after DONE, and the previous outputs hold until then.
